// File: rtl/synapse_current_drive.sv
// rtl/synapse_current_drive.sv - synaptic current generator: event FIFO, saturating accumulator, tick decay
module synapse_current_drive #(
  parameter int I_WIDTH    = 32,
  parameter int W_WIDTH    = 16,
  parameter int W_SHIFT    = 8,
  parameter int TAU_SHIFT  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clear,
  input  logic               decay_tick,
  input  logic               spike_valid,
  input  logic [W_WIDTH-1:0] spike_weight,
  output logic               spike_ready,
  output logic [I_WIDTH-1:0] i_out,
  output logic               busy,
  output logic [7:0]         sat_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = I_WIDTH + 2;
  localparam logic signed [SW-1:0] MAX_EXT = {3'b000, {(I_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_EXT = {3'b111, {(I_WIDTH-1){1'b0}}};

  logic [W_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               empty;
  logic               full;
  logic               push;
  logic               pop;
  logic [W_WIDTH-1:0] head;

  logic signed [SW-1:0]      acc_ext;
  logic signed [SW-1:0]      w_ext;
  logic signed [SW-1:0]      d_ext;
  logic signed [SW-1:0]      sum;
  logic                      clamp;
  logic        [I_WIDTH-1:0] acc_next;

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = spike_valid && !full && !clear;
  assign pop   = en && !empty && !clear;
  assign head  = mem[rd_ptr[AW-1:0]];

  assign spike_ready = !full;
  assign busy        = !empty;

  always_comb begin
    acc_ext = $signed({{2{i_out[I_WIDTH-1]}}, i_out});
    w_ext   = '0;
    if (pop)
      w_ext = $signed({{(SW-W_WIDTH){head[W_WIDTH-1]}}, head}) <<< W_SHIFT;
    d_ext = '0;
    if (decay_tick)
      d_ext = acc_ext >>> TAU_SHIFT;
    sum      = acc_ext - d_ext + w_ext;
    clamp    = 1'b0;
    acc_next = sum[I_WIDTH-1:0];
    if (sum > MAX_EXT) begin
      clamp    = 1'b1;
      acc_next = MAX_EXT[I_WIDTH-1:0];
    end else if (sum < MIN_EXT) begin
      clamp    = 1'b1;
      acc_next = MIN_EXT[I_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= spike_weight;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      i_out     <= '0;
      sat_count <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      i_out     <= '0;
      sat_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
      if (en) begin
        i_out <= acc_next;
        if (clamp && sat_count != 8'hFF)
          sat_count <= sat_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_synapse_current_drive.sv
// tb/tb_synapse_current_drive.sv - directed self-checking bench for synapse_current_drive
module tb_synapse_current_drive;

  logic clk = 1'b0;
  logic rst_n, en, clear, decay_tick;
  logic spike_valid;
  logic [15:0] spike_weight;
  logic spike_ready, busy;
  logic signed [31:0] i_out;
  logic [7:0] sat_count;

  logic s_valid;
  logic [15:0] s_weight;
  logic s_ready, s_busy;
  logic signed [31:0] s_i;
  logic [7:0] s_sat;

  int checks = 0;
  int errors = 0;

  localparam longint IMAX = 64'sd2147483647;
  localparam longint IMIN = -64'sd2147483648;

  always #5 clk = ~clk;

  synapse_current_drive dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .decay_tick(decay_tick),
    .spike_valid(spike_valid), .spike_weight(spike_weight), .spike_ready(spike_ready),
    .i_out(i_out), .busy(busy), .sat_count(sat_count)
  );

  // Wider weight scaling so a handful of events reaches the rails.
  synapse_current_drive #(.W_SHIFT(16)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .decay_tick(decay_tick),
    .spike_valid(s_valid), .spike_weight(s_weight), .spike_ready(s_ready),
    .i_out(s_i), .busy(s_busy), .sat_count(s_sat)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; decay_tick = 1'b0;
    spike_valid = 1'b0; spike_weight = '0; s_valid = 1'b0; s_weight = '0;
    #12;
    chk("reset_i_out", i_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready", spike_ready, 1);
    chk("reset_sat", sat_count, 0);
    rst_n = 1'b1;
    tick();

    // single event, one-cycle latency
    en = 1'b1; spike_valid = 1'b1; spike_weight = 16'd100;
    tick();
    spike_valid = 1'b0;
    chk("single_busy_accept", busy, 1);
    chk("single_i_before_pop", i_out, 0);
    tick();
    chk("single_i_out", i_out, 25600);
    chk("single_busy_after", busy, 0);

    // decay positive
    clear = 1'b1; tick(); clear = 1'b0;
    spike_valid = 1'b1; spike_weight = 16'd16; tick(); spike_valid = 1'b0; tick();
    chk("decay_pos_setup", i_out, 4096);
    decay_tick = 1'b1; tick(); decay_tick = 1'b0;
    chk("decay_pos", i_out, 3840);
    en = 1'b0; decay_tick = 1'b1; tick(); decay_tick = 1'b0; en = 1'b1;
    chk("decay_en0_hold", i_out, 3840);
    tick();
    chk("decay_not_deferred", i_out, 3840);

    // decay negative
    clear = 1'b1; tick(); clear = 1'b0;
    spike_valid = 1'b1; spike_weight = -16'sd16; tick(); spike_valid = 1'b0; tick();
    chk("decay_neg_setup", i_out, -4096);
    decay_tick = 1'b1; tick(); decay_tick = 1'b0;
    chk("decay_neg", i_out, -3840);

    // backpressure: fill with en=0
    clear = 1'b1; tick(); clear = 1'b0;
    en = 1'b0; spike_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      spike_weight = 16'(k);
      tick();
    end
    chk("bp_ready_full", spike_ready, 0);
    spike_weight = 16'd5; tick();
    chk("bp_ready_still0", spike_ready, 0);
    chk("bp_i_frozen", i_out, 0);
    spike_valid = 1'b0; en = 1'b1;
    tick();
    chk("bp_pop1", i_out, 256);
    chk("bp_ready_reassert", spike_ready, 1);
    tick(); chk("bp_pop2", i_out, 768);
    tick(); chk("bp_pop3", i_out, 1536);
    tick(); chk("bp_pop4", i_out, 2560);
    chk("bp_busy_done", busy, 0);
    tick(); chk("bp_no_fifth", i_out, 2560);

    // clear with pending events, decay tick and an offered event
    en = 1'b0; spike_valid = 1'b1; spike_weight = 16'd7; tick(); tick();
    chk("clr_busy_before", busy, 1);
    clear = 1'b1; decay_tick = 1'b1; spike_weight = 16'd9;
    chk("clr_ready_seen", spike_ready, 1);
    tick();
    clear = 1'b0; decay_tick = 1'b0; spike_valid = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_i_out", i_out, 0);
    chk("clr_sat", sat_count, 0);
    en = 1'b1; tick();
    chk("clr_event_lost", i_out, 0);

    // saturation on the wide-shift instance
    s_valid = 1'b1; s_weight = 16'sd32767;
    tick();
    tick(); chk("sat_pos_first", s_i, 2147418112); chk("sat_cnt0", s_sat, 0);
    tick(); chk("sat_pos_clamp1", s_i, IMAX); chk("sat_cnt1", s_sat, 1);
    tick(); chk("sat_pos_clamp2", s_i, IMAX); chk("sat_cnt2", s_sat, 2);
    s_weight = -16'sd32768;
    tick(); chk("sat_pos_clamp3", s_i, IMAX); chk("sat_cnt3", s_sat, 3);
    tick(); chk("sat_swing", s_i, -1); chk("sat_cnt3b", s_sat, 3);
    tick(); chk("sat_neg_clamp1", s_i, IMIN); chk("sat_cnt4", s_sat, 4);
    tick(); chk("sat_neg_clamp2", s_i, IMIN); chk("sat_cnt5", s_sat, 5);
    s_valid = 1'b0;
    tick(); tick();
    chk("sat_idle", s_busy, 0);

    // async reset mid-stream with queued events
    spike_valid = 1'b1; spike_weight = 16'd3; tick(); spike_valid = 1'b0; tick();
    chk("rst_pre_i", i_out, 768);
    en = 1'b0; spike_valid = 1'b1;
    tick(); tick(); tick();
    spike_valid = 1'b0;
    chk("rst_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_i", i_out, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_sat", s_sat, 0);
    chk("rst_async_sat_i", s_i, 0);
    tick();
    rst_n = 1'b1; en = 1'b1;
    tick();
    chk("rst_ready_after", spike_ready, 1);
    chk("rst_no_stale_pop", i_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
